fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch producer on the write side of the IF/ID latch. Owns the PC,
//  requests one instruction at a time from the instruction memory (iREN/ihit) and
//  presents instruction, PC, PC+4 and predicted next PC with a valid/ready handshake.
//  Takes redirects from branch/jump resolution and a halt from the pipeline.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  BTB_ENTRIES  16             BTB depth, power of 2, >=2 (FETCH_BTB_EN builds only)
// PORTS
//  CLK            in   1   clock, all state updates on the rising edge
//  RST            in   1   reset, synchronous, active-high
//  iren           out  1   instruction read request to imem
//  iaddr          out  32  request address; stable while iren=1 and ihit=0
//  ihit           in   1   imem response valid for the current request
//  iload          in   32  imem read data, sampled when ihit=1
//  out_valid      out  1   instruction bundle valid toward the IF/ID latch
//  out_ready      in   1   IF/ID latch enable; a transfer occurs when out_valid & out_ready
//  imemload_out   out  32  fetched instruction
//  inst_pc_out    out  32  PC of the fetched instruction
//  pcp4_out       out  32  inst_pc_out + 4
//  pred_pc_out    out  32  predicted next PC
//  redirect       in   1   one-cycle pulse: resume fetch at redirect_pc
//  redirect_pc    in   32  redirect target, word aligned
//  halt           in   1   stop fetching until reset
//  btb_upd        in   1   BTB write strobe (FETCH_BTB_EN builds only)
//  btb_upd_pc     in   32  PC of the resolved branch (FETCH_BTB_EN builds only)
//  btb_upd_tgt    in   32  resolved taken target (FETCH_BTB_EN builds only)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=REQ, hold regs=0. While RST=1: iren=0, out_valid=0,
//   all bundle outputs 0.
//  States:
//   REQ    iren=1, iaddr=pc.
//   HOLD   iren=0; bundle is driven from hold registers.
//   DRAIN  iren=1, iaddr=old pc; the response is discarded.
//   HALTED iren=0, out_valid=0.
//  Bundle in REQ comes straight from iload, so out_valid=ihit & ~redirect (zero latency).
//  Per-cycle priority: RST > halt > redirect > normal flow.
//  REQ:
//   - ihit & out_ready: pc<=pred, stay in REQ, giving back-to-back fetch.
//   - ihit & ~out_ready: capture the bundle, go to HOLD.
//   - ~ihit: stay in REQ.
//  HOLD:
//   - out_ready: pc<=pred, go to REQ.
//   - otherwise hold the bundle unchanged.
//  Redirect:
//   - in REQ with ihit: drop the response, pc<=redirect_pc, stay in REQ.
//   - in REQ without ihit: the imem request cannot be withdrawn, so latch pend_pc and go to DRAIN.
//   - in HOLD: discard the bundle, pc<=redirect_pc, go to REQ.
//   - in DRAIN: overwrite pend_pc.
//  DRAIN: out_valid=0; on ihit, pc<=pend_pc and go to REQ.
//  Halt:
//   - in REQ or HOLD: go to HALTED now, even with an imem request outstanding.
//   - in DRAIN: finish the drain first, then go to HALTED.
//   - HALTED is left only by reset.
//  Arithmetic: PC adds are 32-bit with wrap, so 32'hFFFF_FFFC+4 = 0. pc[1:0] is forced to 0.
// CONFIGURATION
//  FETCH_BTB_EN defined:
//   - Direct-mapped BTB with BTB_ENTRIES entries, indexed by pc[log2(N)+1:2].
//     Each entry holds valid, tag (remaining upper bits) and target.
//   - Hit: pred=target. Miss: pred=pc+4.
//   - btb_upd writes in one cycle; the new entry is visible to a lookup on the next cycle.
//   - Reset clears all valid bits.
//  FETCH_BTB_EN undefined:
//   - pred=pc+4. The btb_* ports exist but are ignored. No BTB storage.
// STRUCTURE
//  cpu_types_pkg: word_t, fetch_state_t {REQ,HOLD,DRAIN,HALTED}, PC_INC=32'd4.
//  Sub-module fetch_btb (lookup pc -> hit/target, update port), instantiated only under FETCH_BTB_EN.
// TESTING
//  1 Reset release, ihit every cycle, out_ready=1 -> inst_pc_out 0,4,8,12 on consecutive cycles.
//  2 ihit at pc=8 with out_ready=0 for 3 cycles -> iren=0, bundle held at 8, then pc 12 is requested.
//  3 redirect=1, redirect_pc=0x40 while REQ waits on ihit -> DRAIN, old response gets no out_valid, next iaddr=0x40.
//  4 redirect during HOLD -> held bundle never transfers, next iaddr=redirect_pc.
//  5 halt in REQ -> iren=0 and out_valid=0 from the next cycle, indefinitely; RST=1 -> iaddr=RESET_PC.
//  6 FETCH_BTB_EN: btb_upd pc=0x10 tgt=0x80, then fetch 0x10 -> pred_pc_out=0x80, next iaddr=0x80.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared fetch types: word, fetch FSM states, PC increment and alignment helper.
// Pure declarations, no logic; imported by fetch_stage and fetch_btb.
// No handshake of its own.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam word_t PC_INC = 32'd4;

    function automatic word_t word_align(input word_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup, single-cycle update.
// Lookup is zero latency; an update becomes visible to lookups on the following cycle.
// No backpressure: an update strobe is always accepted.
module fetch_btb
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] i_lkp_pc,
    output logic        o_hit,
    output logic [31:0] o_tgt,
    input  logic        i_upd_vld,
    input  logic [31:0] i_upd_pc,
    input  logic [31:0] i_upd_tgt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_vld;
    logic [TAG_W-1:0]   r_tag [ENTRIES];
    word_t              r_tgt [ENTRIES];

    logic [IDX_W-1:0] w_lkp_idx;
    logic [TAG_W-1:0] w_lkp_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_unused;

    assign w_lkp_idx = i_lkp_pc[IDX_W+1:2];
    assign w_lkp_tag = i_lkp_pc[31:IDX_W+2];
    assign w_upd_idx = i_upd_pc[IDX_W+1:2];
    assign w_upd_tag = i_upd_pc[31:IDX_W+2];
    // Byte-offset bits never participate in index or tag.
    assign w_unused  = ^{i_lkp_pc[1:0], i_upd_pc[1:0]};

    assign o_hit = r_vld[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
    assign o_tgt = r_tgt[w_lkp_idx];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld <= '0;
        end else if (i_upd_vld) begin
            r_vld[w_upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_upd_vld) begin
            r_tag[w_upd_idx] <= w_upd_tag;
            r_tgt[w_upd_idx] <= i_upd_tgt;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch producer feeding the IF/ID latch; optional BTB prediction under FETCH_BTB_EN.
// Zero latency: in REQ the bundle is combinational from iload/ihit.
// ~out_ready parks the bundle in hold registers and stops imem requests until accepted.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        iren,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] imemload_out,
    output logic [31:0] inst_pc_out,
    output logic [31:0] pcp4_out,
    output logic [31:0] pred_pc_out,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        btb_upd,
    input  logic [31:0] btb_upd_pc,
    input  logic [31:0] btb_upd_tgt
);

    fetch_state_t r_state;
    word_t        r_pc;
    word_t        r_pend_pc;
    word_t        r_hold_inst;
    word_t        r_hold_pred;
    logic         r_halt_pend;

    word_t w_pcp4;
    word_t w_pred;
    word_t w_redir_pc;
    word_t w_pend_nxt;
    logic  w_is_req;
    logic  w_is_hold;
    logic  w_is_drain;

    assign w_pcp4     = r_pc + PC_INC;
    assign w_redir_pc = word_align(redirect_pc);
    assign w_pend_nxt = redirect ? w_redir_pc : r_pend_pc;
    assign w_is_req   = (r_state == REQ);
    assign w_is_hold  = (r_state == HOLD);
    assign w_is_drain = (r_state == DRAIN);

`ifdef FETCH_BTB_EN
    logic  w_btb_hit;
    word_t w_btb_tgt;

    fetch_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .CLK       (CLK),
        .RST       (RST),
        .i_lkp_pc  (r_pc),
        .o_hit     (w_btb_hit),
        .o_tgt     (w_btb_tgt),
        .i_upd_vld (btb_upd),
        .i_upd_pc  (btb_upd_pc),
        .i_upd_tgt (btb_upd_tgt)
    );

    assign w_pred = w_btb_hit ? word_align(w_btb_tgt) : w_pcp4;
`else
    logic w_unused;

    // Without a BTB the update port is accepted and dropped.
    assign w_unused = ^{btb_upd, btb_upd_pc, btb_upd_tgt, (BTB_ENTRIES > 1)};
    assign w_pred   = w_pcp4;
`endif

    assign iren      = ~RST & (w_is_req | w_is_drain);
    assign iaddr     = r_pc;
    assign out_valid = ~RST & ~redirect & ((w_is_req & ihit) | w_is_hold);

    always_comb begin
        imemload_out = '0;
        inst_pc_out  = '0;
        pcp4_out     = '0;
        pred_pc_out  = '0;
        if (!RST) begin
            if (w_is_req) begin
                imemload_out = iload;
                inst_pc_out  = r_pc;
                pcp4_out     = w_pcp4;
                pred_pc_out  = w_pred;
            end else if (w_is_hold) begin
                imemload_out = r_hold_inst;
                inst_pc_out  = r_pc;
                pcp4_out     = w_pcp4;
                pred_pc_out  = r_hold_pred;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= REQ;
            r_pc        <= word_align(RESET_PC);
            r_pend_pc   <= '0;
            r_hold_inst <= '0;
            r_hold_pred <= '0;
            r_halt_pend <= 1'b0;
        end else begin
            case (r_state)
                REQ: begin
                    if (halt) begin
                        r_state <= HALTED;
                    end else if (redirect) begin
                        if (ihit) begin
                            r_pc <= w_redir_pc;
                        end else begin
                            // The outstanding imem request cannot be withdrawn.
                            r_pend_pc   <= w_redir_pc;
                            r_halt_pend <= 1'b0;
                            r_state     <= DRAIN;
                        end
                    end else if (ihit) begin
                        if (out_ready) begin
                            r_pc <= w_pred;
                        end else begin
                            r_hold_inst <= iload;
                            r_hold_pred <= w_pred;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (halt) begin
                        r_state <= HALTED;
                    end else if (redirect) begin
                        r_pc    <= w_redir_pc;
                        r_state <= REQ;
                    end else if (out_ready) begin
                        r_pc    <= r_hold_pred;
                        r_state <= REQ;
                    end
                end
                DRAIN: begin
                    r_pend_pc <= w_pend_nxt;
                    if (halt) begin
                        r_halt_pend <= 1'b1;
                    end
                    if (ihit) begin
                        if (halt || r_halt_pend) begin
                            r_state <= HALTED;
                        end else begin
                            r_pc    <= w_pend_nxt;
                            r_state <= REQ;
                        end
                    end
                end
                default: begin
                    r_state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected bundles drained by a monitor,
// plus direct checks on the imem request side.
module tb_fetch_stage;

    localparam logic [31:0] IMEM_KEY = 32'h5EED_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] pred;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        iren;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imemload_out;
    logic [31:0] inst_pc_out;
    logic [31:0] pcp4_out;
    logic [31:0] pred_pc_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        btb_upd;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_tgt;
    logic        ihit_en;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] old_pc;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .iren         (iren),
        .iaddr        (iaddr),
        .ihit         (ihit),
        .iload        (iload),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .imemload_out (imemload_out),
        .inst_pc_out  (inst_pc_out),
        .pcp4_out     (pcp4_out),
        .pred_pc_out  (pred_pc_out),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .btb_upd      (btb_upd),
        .btb_upd_pc   (btb_upd_pc),
        .btb_upd_tgt  (btb_upd_tgt)
    );

    // Zero-wait imem model, gated by ihit_en.
    assign ihit  = ihit_en & iren;
    assign iload = iaddr ^ IMEM_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pred);
        exp_t e;
        e.pc   = pc;
        e.inst = pc ^ IMEM_KEY;
        e.pcp4 = pc + 32'd4;
        e.pred = pred;
        sb_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        ihit_en = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_xfer", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("xfer_inst", imemload_out, e.inst);
                chk("xfer_pc",   inst_pc_out,  e.pc);
                chk("xfer_pcp4", pcp4_out,     e.pcp4);
                chk("xfer_pred", pred_pc_out,  e.pred);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ihit_en = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        halt = 1'b0; btb_upd = 1'b0; btb_upd_pc = '0; btb_upd_tgt = '0;
        tick;
        tick;
        @(negedge clk);
        chk("rst_iren",    {31'd0, iren},      32'd0);
        chk("rst_valid",   {31'd0, out_valid}, 32'd0);
        chk("rst_inst_pc", inst_pc_out,        32'd0);
        chk("rst_pred",    pred_pc_out,        32'd0);

        // Back-to-back fetch 0,4,8,12
        tick;
        rst = 1'b0; ihit_en = 1'b1;
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC); push(32'hC, 32'h10);
        repeat (4) tick;
        ihit_en = 1'b0;
        @(negedge clk);
        chk("t1_next_iaddr", iaddr, 32'h10);

        // Backpressure at pc=8
        do_reset;
        ihit_en = 1'b1;
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC);
        tick;
        tick;
        out_ready = 1'b0;
        tick;
        ihit_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_iren",  {31'd0, iren},      32'd0);
            chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_hold_pc",    inst_pc_out,        32'h8);
            chk("t2_hold_inst",  imemload_out,       32'h8 ^ IMEM_KEY);
            tick;
        end
        out_ready = 1'b1;
        tick;
        @(negedge clk);
        chk("t2_req_iren",  {31'd0, iren}, 32'd1);
        chk("t2_req_iaddr", iaddr,         32'hC);

        // Redirect while REQ waits on ihit -> DRAIN
        tick;
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        chk("t3_redir_valid", {31'd0, out_valid}, 32'd0);
        tick;
        redirect = 1'b0; ihit_en = 1'b1;
        @(negedge clk);
        chk("t3_drain_iren",  {31'd0, iren},      32'd1);
        chk("t3_drain_iaddr", iaddr,              32'hC);
        chk("t3_drain_valid", {31'd0, out_valid}, 32'd0);
        tick;
        push(32'h40, 32'h44);
        @(negedge clk);
        chk("t3_new_iaddr", iaddr, 32'h40);
        tick;
        ihit_en = 1'b0;

        // Redirect during HOLD
        out_ready = 1'b0; ihit_en = 1'b1;
        @(negedge clk);
        chk("t4_pre_valid", {31'd0, out_valid}, 32'd1);
        tick;
        ihit_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
        @(negedge clk);
        chk("t4_redir_valid", {31'd0, out_valid}, 32'd0);
        tick;
        redirect = 1'b0;
        @(negedge clk);
        chk("t4_iren",  {31'd0, iren}, 32'd1);
        chk("t4_iaddr", iaddr,         32'h100);

        // Redirect with ihit drops the response; PC wrap at top of memory
        tick;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; ihit_en = 1'b1;
        @(negedge clk);
        chk("wrap_drop_valid", {31'd0, out_valid}, 32'd0);
        tick;
        redirect = 1'b0;
        push(32'hFFFF_FFFC, 32'h0);
        tick;
        ihit_en = 1'b0;
        @(negedge clk);
        chk("wrap_iaddr", iaddr, 32'h0);
        old_pc = 32'h0;

`ifdef FETCH_BTB_EN
        tick;
        btb_upd = 1'b1; btb_upd_pc = 32'h10; btb_upd_tgt = 32'h80;
        redirect = 1'b1; redirect_pc = 32'h10; ihit_en = 1'b1;
        tick;
        btb_upd = 1'b0; redirect = 1'b0;
        push(32'h10, 32'h80);
        tick;
        ihit_en = 1'b0;
        @(negedge clk);
        chk("t6_btb_iaddr", iaddr, 32'h80);
        old_pc = 32'h80;
`endif

        // Halt while draining: drain completes, then halted
        tick;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick;
        redirect = 1'b0; halt = 1'b1;
        tick;
        halt = 1'b0;
        @(negedge clk);
        chk("t7_drain_iren",  {31'd0, iren}, 32'd1);
        chk("t7_drain_iaddr", iaddr,         old_pc);
        ihit_en = 1'b1;
        tick;
        @(negedge clk);
        chk("t7_halt_iren",  {31'd0, iren},      32'd0);
        chk("t7_halt_valid", {31'd0, out_valid}, 32'd0);

        // Halt in REQ, then reset
        do_reset;
        ihit_en = 1'b1;
        push(32'h0, 32'h4);
        tick;
        ihit_en = 1'b0; halt = 1'b1;
        tick;
        halt = 1'b0; ihit_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_halt_iren",  {31'd0, iren},      32'd0);
            chk("t5_halt_valid", {31'd0, out_valid}, 32'd0);
            tick;
        end
        rst = 1'b1;
        tick;
        @(negedge clk);
        chk("t5_rst_iaddr", iaddr,              32'h0);
        chk("t5_rst_iren",  {31'd0, iren},      32'd0);
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0; ihit_en = 1'b0;
        tick;
        @(negedge clk);
        chk("t5_restart_iren", {31'd0, iren}, 32'd1);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
